align_fifo: RTL and testbench



---
 rtl/align_fifo.sv | 98 +++++++++
 tb/tb_align_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/align_fifo.sv
// align_fifo: first-word-fall-through buffer behind the serial-to-parallel aligner.
// Push-only input; it raises full/almost_full for throttling and sets a sticky overflow on a dropped word.
module align_fifo #(
    parameter int DATA_BIT     = 256,
    parameter int DEPTH        = 4,
    parameter int AFULL_MARGIN = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_BIT-1:0]          idata,
    input  logic                         idata_valid,
    output logic [DATA_BIT-1:0]          odata,
    output logic                         odata_valid,
    input  logic                         odata_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         almost_full,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AFULL_MARGIN);

    logic [DATA_BIT-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_overflow;

    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_full  = (r_count == FULL_LEVEL);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && odata_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign w_push  = idata_valid && (!w_full || w_pop);
    assign w_drop  = idata_valid && w_full && !w_pop;

    assign odata       = r_mem[r_rd_ptr];
    assign odata_valid = w_valid;
    assign count       = r_count;
    assign full        = w_full;
    assign almost_full = (AFULL_MARGIN >= DEPTH) ? 1'b1 : (r_count >= AF_LEVEL);
    assign overflow    = r_overflow;

    // Storage writes; reset zeroes every entry so odata reads 0 when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= idata;
        end
    end

    // Pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy: moves only when exactly one of push/pop happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_align_fifo.sv
// tb_align_fifo: directed stimulus for align_fifo with a queue-based scoreboard.
// The stimulus pushes the expected words, and a negedge monitor pops and compares each accepted head.
module tb_align_fifo;

    localparam int DW = 256;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] idata;
    logic          idata_valid;
    logic [DW-1:0] odata;
    logic          odata_valid;
    logic          odata_ready;
    logic [2:0]    count;
    logic          full;
    logic          almost_full;
    logic          overflow;

    int n_total = 0;
    int n_pass  = 0;

    logic [DW-1:0] sb [$];

    align_fifo #(.DATA_BIT(DW), .DEPTH(DEPTH), .AFULL_MARGIN(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .idata       (idata),
        .idata_valid (idata_valid),
        .odata       (odata),
        .odata_valid (odata_valid),
        .odata_ready (odata_ready),
        .count       (count),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w, input bit expect_accept);
        idata       = w;
        idata_valid = 1'b1;
        if (expect_accept) sb.push_back(w);
        tick();
        idata_valid = 1'b0;
    endtask

    task automatic fill(input int n, input logic [DW-1:0] base);
        odata_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            push_word(base + DW'(i), 1'b1);
            chk("fill_count", DW'(count), DW'(i + 1));
            chk("fill_afull", DW'(almost_full), DW'(i + 1 >= 3));
            chk("fill_full", DW'(full), DW'(i + 1 == 4));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    // Monitor: every accepted head must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && odata_valid === 1'b1 && odata_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_extra: got %h expected nothing", odata);
            end else begin
                chk("sb_data", odata, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] w;
        rst = 1'b1;
        idata = '0;
        idata_valid = 1'b0;
        odata_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset then idle with ready high
        chk("rst_count", DW'(count), '0);
        chk("rst_valid", DW'(odata_valid), '0);
        chk("rst_odata", odata, '0);
        chk("rst_full", DW'(full), '0);
        chk("rst_afull", DW'(almost_full), '0);
        chk("rst_ovf", DW'(overflow), '0);
        odata_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_count", DW'(count), '0);
            chk("idle_valid", DW'(odata_valid), '0);
            chk("idle_odata", odata, '0);
        end

        // fill and drain
        fill(4, DW'(8'hA0));
        odata_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        odata_ready = 1'b0;
        chk("drain_valid", DW'(odata_valid), '0);
        chk("drain_count", DW'(count), '0);
        chk("drain_sb", DW'(sb.size()), '0);

        // overflow: the extra word is dropped
        fill(4, DW'(8'hA0));
        push_word(DW'(8'hFF), 1'b0);
        chk("ovf_count", DW'(count), DW'(4));
        chk("ovf_flag", DW'(overflow), DW'(1));
        odata_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        odata_ready = 1'b0;
        tick();
        chk("ovf_empty", DW'(odata_valid), '0);
        chk("ovf_sticky", DW'(overflow), DW'(1));
        chk("ovf_sb", DW'(sb.size()), '0);

        // full with simultaneous push and pop
        do_reset();
        chk("rst2_ovf", DW'(overflow), '0);
        fill(4, DW'(8'hA0));
        odata_ready = 1'b1;
        push_word(DW'(8'hB0), 1'b1);
        chk("fpp_count", DW'(count), DW'(4));
        chk("fpp_ovf", DW'(overflow), '0);
        for (int i = 0; i < 4; i++) tick();
        chk("fpp_empty", DW'(count), '0);
        chk("fpp_sb", DW'(sb.size()), '0);

        // wrap-around streaming
        odata_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            w = DW'(32'h100 + i);
            push_word(w, 1'b1);
            idata_valid = 1'b0;
            chk("wrap_odata", odata, w);
            chk("wrap_count", DW'(count), DW'(1));
        end
        tick();
        chk("wrap_end", DW'(count), '0);
        chk("wrap_sb", DW'(sb.size()), '0);

        // reset mid-operation at count 3; write in reset cycle ignored
        fill(3, DW'(8'hA0));
        rst = 1'b1;
        idata = DW'(8'hEE);
        idata_valid = 1'b1;
        tick();
        rst = 1'b0;
        idata_valid = 1'b0;
        sb.delete();
        chk("mid_count", DW'(count), '0);
        chk("mid_valid", DW'(odata_valid), '0);
        chk("mid_odata", odata, '0);
        push_word(DW'(8'hC0), 1'b1);
        chk("mid_push_valid", DW'(odata_valid), DW'(1));
        chk("mid_push_odata", odata, DW'(8'hC0));
        odata_ready = 1'b1;
        tick();
        odata_ready = 1'b0;
        chk("mid_end", DW'(count), '0);
        chk("final_sb", DW'(sb.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
